dmem_bridge: RTL and testbench
==============================

Name: dmem_bridge

Overview:
- Parametrised data-memory bridge between `riscv_core`'s load/store port and a byte-write dual-port BRAM.
- Generates byte/half/word write enables and aligns load data with sign or zero extension.
- Tracks a configurable BRAM read latency with an in-order response pipeline.
- Decodes a small MMIO window: cycle counter, plus a `tohost` register that halts the bridge on program completion.

Parameters:
- ADDR_WIDTH, 16, byte-address bits reaching BRAM; the BRAM word address is `req_addr_in[ADDR_WIDTH-1:2]`.
- READ_LATENCY, 2, cycles from accept to response; legal range 1..3 (2 matches HIGH_PERFORMANCE BRAM).
- MMIO_BASE, 32'h8000_0000, base of the MMIO window; decoded on bits [31:28].

Ports:
- clk_in  input  1  clock
- rst_in  input  1  asynchronous active-high reset
- req_valid_in  input  1  core presents a request
- req_ready_out  output  1  bridge accepts; transfer occurs on valid&&ready
- req_write_in  input  1  1=store, 0=load
- req_addr_in  input  32  byte address
- req_wdata_in  input  32  store data, LSB-justified
- req_size_in  input  2  00=byte, 01=half, 10=word; 11 is illegal and causes an error
- req_unsigned_in  input  1  zero-extend loads (LBU/LHU)
- rsp_valid_out  output  1  response for the oldest accepted request
- rsp_rdata_out  output  32  extended load data; 0 for stores and errors
- rsp_error_out  output  1  misaligned or illegal access
- mem_addr_out  output  ADDR_WIDTH-2  BRAM word address
- mem_wdata_out  output  32  lane-replicated store data
- mem_we_out  output  4  byte write enables
- mem_en_out  output  1  BRAM enable
- mem_rdata_in  input  32  BRAM read data, valid READ_LATENCY-1 cycles after `mem_en_out`
- tohost_valid_out  output  1  sticky: program signalled done
- tohost_data_out  output  32  last value written to TOHOST
- cycle_out  output  32  free-running cycle count

Behaviour:
- Reset values (asynchronous):
  - `rsp_valid_out`, `rsp_rdata_out` and `rsp_error_out` are 0.
  - `tohost_valid_out` and `tohost_data_out` are 0, `cycle_out` is 0, and the state is RUN.
  - The response pipeline is flushed; requests in flight at reset produce no response.
- `req_ready_out` is high only when `rst_in` is low and the state is RUN.
- States:
  - RUN → HALT on an accepted word store to TOHOST with `wdata[0]=1`.
  - HALT is left only by reset.
  - In HALT, requests already in flight still drain their responses.
- Decode:
  - MMIO when `addr[31:28]==MMIO_BASE[31:28]`. CYCLE is at offset 0x0 (read-only; stores ignored, no error). TOHOST is at offset 0x4 (read/write).
  - Any other MMIO offset, or non-word MMIO access, is an error.
  - Non-MMIO addresses alias modulo 2^ADDR_WIDTH.
- Alignment error: half access with `addr[0]=1`, word access with `addr[1:0]!=0`, or size 11. An erroring request drives `mem_we_out=0` and `mem_en_out=0`, and has no MMIO side effect.
- Memory port (combinational from an accepted non-MMIO, non-error request; otherwise `mem_en_out=0` and `mem_we_out=0`):
  - Byte store: `we = 4'b0001<<addr[1:0]`, `wdata = {4{wdata[7:0]}}`.
  - Half store: `we = addr[1] ? 1100 : 0011`, `wdata = {2{wdata[15:0]}}`.
  - Word store: `we = 1111`.
  - Loads: `we = 0`, `en = 1`.
- Response timing:
  - Every accepted request yields exactly one response, in order, exactly READ_LATENCY cycles after accept.
  - Back-to-back accepts give back-to-back responses.
  - A shift pipeline of depth READ_LATENCY carries: valid, write, size, unsigned, `addr[1:0]`, mmio, error, and the MMIO read value.
- Load alignment: the selected lane is shifted to bit 0, then sign-extended unless unsigned.
- MMIO reads return the value sampled at the accept cycle.
- Cycle counter: +1 every cycle in RUN, frozen in HALT, wraps 0xFFFF_FFFF→0.
- A TOHOST store updates `tohost_data_out` on the clock edge after accept. `tohost_valid_out` is set at the same edge when bit 0 is 1.

Decomposition:
- Package `dmem_pkg`: size enum (SIZE_B/SIZE_H/SIZE_W), MMIO offsets (MMIO_CYCLE=0x0, MMIO_TOHOST=0x4), state enum (RUN/HALT), and the pipeline tag struct.
- Sub-module `dmem_align`: purely combinational store lane/WE generation and load extract/extend, shared by both paths.

Test Plan:
- Store byte 0xA5 at addr 0x0000_0103 → `mem_we_out=4'b1000`, `mem_wdata_out=0xA5A5A5A5`. A following LB at the same address returns 0xFFFF_FFA5; LBU returns 0x0000_00A5. Both respond 2 cycles after accept.
- Word at addr 0x10 holds 0x8001_7FFF:
  - LH @0x12 → 0xFFFF_8001.
  - LHU @0x10 → 0x0000_7FFF.
  - Four back-to-back loads → four consecutive `rsp_valid_out` cycles, in order.
- LW @0x0000_0006 → `rsp_error_out=1`, `rsp_rdata_out=0`, `mem_en_out=0`. SH @0x0000_0001 → error, `mem_we_out=0`, memory unchanged.
- LW @0x8000_0000 after N cycles → returns N (cycle value at accept). SW 0x1 to 0x8000_0004 → next edge `tohost_valid_out=1`, `tohost_data_out=1`, then `req_ready_out=0` and `cycle_out` frozen. The SW's own response still appears.
- Assert `rst_in` while two loads are in flight → no `rsp_valid_out` after reset. All outputs are 0 and `req_ready_out` is high one cycle after release.
- With READ_LATENCY=1 and 3: LW @0x20 → response exactly 1 or 3 cycles after accept respectively. Also check `cycle_out` wraps from 0xFFFF_FFFF to 0 via forced preload.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bridge: access sizes, MMIO offsets,
// bridge state and the tag carried down the response pipeline.
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } size_e;

  localparam logic [27:0] MMIO_CYCLE  = 28'h000_0000;
  localparam logic [27:0] MMIO_TOHOST = 28'h000_0004;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic        mmio;
    logic        error;
    logic [31:0] mmio_rdata;
  } tag_t;

endpackage

// File: rtl/dmem_align.sv
// Combinational lane logic: store byte-enables/lane replication and
// load lane extraction with sign or zero extension.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_we,
  output logic [31:0] st_lanes,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_uns,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    st_we    = 4'b0000;
    st_lanes = st_data;
    case (st_size)
      SIZE_B: begin
        st_we    = 4'b0001 << st_off;
        st_lanes = {4{st_data[7:0]}};
      end
      SIZE_H: begin
        st_we    = st_off[1] ? 4'b1100 : 4'b0011;
        st_lanes = {2{st_data[15:0]}};
      end
      SIZE_W:  st_we = 4'b1111;
      default: st_we = 4'b0000;
    endcase
  end

  // Selected lane is brought down to bit 0 before extension.
  always_comb begin
    shifted = ld_word >> {ld_off, 3'b000};
    ld_data = shifted;
    case (ld_size)
      SIZE_B:  ld_data = ld_uns ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_H:  ld_data = ld_uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// Load/store bridge from the core to a byte-write BRAM with a fixed-latency
// in-order response pipeline and a small MMIO window (cycle counter, tohost).
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 16,
  parameter int          READ_LATENCY = 2,
  parameter logic [31:0] MMIO_BASE    = 32'h8000_0000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  // Request handshake: a transfer happens in any cycle where req_valid_in && req_ready_out.
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic                  req_write_in,
  input  logic [31:0]           req_addr_in,
  input  logic [31:0]           req_wdata_in,
  input  logic [1:0]            req_size_in,
  input  logic                  req_unsigned_in,
  output logic                  rsp_valid_out,
  output logic [31:0]           rsp_rdata_out,
  output logic                  rsp_error_out,
  output logic [ADDR_WIDTH-3:0] mem_addr_out,
  output logic [31:0]           mem_wdata_out,
  output logic [3:0]            mem_we_out,
  output logic                  mem_en_out,
  input  logic [31:0]           mem_rdata_in,
  output logic                  tohost_valid_out,
  output logic [31:0]           tohost_data_out,
  output logic [31:0]           cycle_out,
  output state_e                state_out
);

  state_e      state_q;
  logic [31:0] cycle_q;
  logic        accept;
  logic        is_mmio;
  logic [27:0] mmio_off;
  logic        misaligned;
  logic        mmio_bad;
  logic        err;
  logic        tohost_wr;
  logic [3:0]  st_we;
  logic [31:0] st_lanes;
  logic [31:0] ld_data;
  tag_t        cur_tag;
  tag_t        last_tag;

  assign req_ready_out = !rst_in && (state_q == ST_RUN);
  assign accept        = req_valid_in && req_ready_out;
  assign is_mmio       = req_addr_in[31:28] == MMIO_BASE[31:28];
  assign mmio_off      = req_addr_in[27:0] - MMIO_BASE[27:0];

  always_comb begin
    case (req_size_in)
      SIZE_B:  misaligned = 1'b0;
      SIZE_H:  misaligned = req_addr_in[0];
      SIZE_W:  misaligned = req_addr_in[1:0] != 2'b00;
      default: misaligned = 1'b1;
    endcase
  end

  assign mmio_bad  = is_mmio && ((req_size_in != SIZE_W) ||
                                 ((mmio_off != MMIO_CYCLE) && (mmio_off != MMIO_TOHOST)));
  assign err       = misaligned || mmio_bad;
  assign tohost_wr = accept && is_mmio && !err && req_write_in && (mmio_off == MMIO_TOHOST);

  dmem_align u_align (
    .st_size  (req_size_in),
    .st_off   (req_addr_in[1:0]),
    .st_data  (req_wdata_in),
    .st_we    (st_we),
    .st_lanes (st_lanes),
    .ld_size  (last_tag.size),
    .ld_off   (last_tag.off),
    .ld_uns   (last_tag.uns),
    .ld_word  (mem_rdata_in),
    .ld_data  (ld_data)
  );

  assign mem_en_out    = accept && !is_mmio && !err;
  assign mem_we_out    = (mem_en_out && req_write_in) ? st_we : 4'b0000;
  assign mem_wdata_out = st_lanes;
  assign mem_addr_out  = req_addr_in[ADDR_WIDTH-1:2];

  // MMIO read data is captured at accept so later counter ticks do not leak in.
  always_comb begin
    cur_tag            = '0;
    cur_tag.valid      = accept;
    cur_tag.write      = req_write_in;
    cur_tag.size       = req_size_in;
    cur_tag.uns        = req_unsigned_in;
    cur_tag.off        = req_addr_in[1:0];
    cur_tag.mmio       = is_mmio;
    cur_tag.error      = err;
    cur_tag.mmio_rdata = (mmio_off == MMIO_CYCLE) ? cycle_q : tohost_data_out;
  end

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign last_tag = cur_tag;
    end else begin : g_pipe
      tag_t pipe_q [READ_LATENCY-1];
      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
          for (int i = 0; i < READ_LATENCY - 1; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= cur_tag;
          for (int i = 1; i < READ_LATENCY - 1; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign last_tag = pipe_q[READ_LATENCY-2];
    end
  endgenerate

  // The response register is the final pipeline stage; it samples BRAM data here.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rsp_valid_out <= 1'b0;
      rsp_error_out <= 1'b0;
      rsp_rdata_out <= '0;
    end else begin
      rsp_valid_out <= last_tag.valid;
      rsp_error_out <= last_tag.valid && last_tag.error;
      if (!last_tag.valid || last_tag.error || last_tag.write) rsp_rdata_out <= '0;
      else if (last_tag.mmio)                                  rsp_rdata_out <= last_tag.mmio_rdata;
      else                                                     rsp_rdata_out <= ld_data;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q          <= ST_RUN;
      cycle_q          <= '0;
      tohost_valid_out <= 1'b0;
      tohost_data_out  <= '0;
    end else begin
      if (state_q == ST_RUN) cycle_q <= cycle_q + 32'd1;
      if (tohost_wr) begin
        tohost_data_out <= req_wdata_in;
        if (req_wdata_in[0]) begin
          tohost_valid_out <= 1'b1;
          state_q          <= ST_HALT;
        end
      end
    end
  end

  assign cycle_out = cycle_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: three instances (read latency 1, 2, 3) share one request
// stream and one BRAM; a byte-level reference model predicts every response.
module tb_dmem_bridge;
  import dmem_pkg::*;

  localparam int AW     = 16;
  localparam int NWORDS = 1 << (AW - 2);

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  logic        req_valid_in, req_write_in, req_unsigned_in;
  logic [31:0] req_addr_in, req_wdata_in;
  logic [1:0]  req_size_in;

  logic          rdy     [3];
  logic          rsp_v   [3];
  logic [31:0]   rsp_d   [3];
  logic          rsp_e   [3];
  logic [AW-3:0] m_addr  [3];
  logic [31:0]   m_wdata [3];
  logic [3:0]    m_we    [3];
  logic          m_en    [3];
  logic [31:0]   m_rdata [3];
  logic          th_v    [3];
  logic [31:0]   th_d    [3];
  logic [31:0]   cyc     [3];
  state_e        st      [3];

  dmem_bridge #(.ADDR_WIDTH(AW), .READ_LATENCY(1)) u_l1 (
    .clk_in(clk_in), .rst_in(rst_in), .req_valid_in(req_valid_in), .req_ready_out(rdy[0]),
    .req_write_in(req_write_in), .req_addr_in(req_addr_in), .req_wdata_in(req_wdata_in),
    .req_size_in(req_size_in), .req_unsigned_in(req_unsigned_in), .rsp_valid_out(rsp_v[0]),
    .rsp_rdata_out(rsp_d[0]), .rsp_error_out(rsp_e[0]), .mem_addr_out(m_addr[0]),
    .mem_wdata_out(m_wdata[0]), .mem_we_out(m_we[0]), .mem_en_out(m_en[0]),
    .mem_rdata_in(m_rdata[0]), .tohost_valid_out(th_v[0]), .tohost_data_out(th_d[0]),
    .cycle_out(cyc[0]), .state_out(st[0]));

  dmem_bridge #(.ADDR_WIDTH(AW), .READ_LATENCY(2)) u_l2 (
    .clk_in(clk_in), .rst_in(rst_in), .req_valid_in(req_valid_in), .req_ready_out(rdy[1]),
    .req_write_in(req_write_in), .req_addr_in(req_addr_in), .req_wdata_in(req_wdata_in),
    .req_size_in(req_size_in), .req_unsigned_in(req_unsigned_in), .rsp_valid_out(rsp_v[1]),
    .rsp_rdata_out(rsp_d[1]), .rsp_error_out(rsp_e[1]), .mem_addr_out(m_addr[1]),
    .mem_wdata_out(m_wdata[1]), .mem_we_out(m_we[1]), .mem_en_out(m_en[1]),
    .mem_rdata_in(m_rdata[1]), .tohost_valid_out(th_v[1]), .tohost_data_out(th_d[1]),
    .cycle_out(cyc[1]), .state_out(st[1]));

  dmem_bridge #(.ADDR_WIDTH(AW), .READ_LATENCY(3)) u_l3 (
    .clk_in(clk_in), .rst_in(rst_in), .req_valid_in(req_valid_in), .req_ready_out(rdy[2]),
    .req_write_in(req_write_in), .req_addr_in(req_addr_in), .req_wdata_in(req_wdata_in),
    .req_size_in(req_size_in), .req_unsigned_in(req_unsigned_in), .rsp_valid_out(rsp_v[2]),
    .rsp_rdata_out(rsp_d[2]), .rsp_error_out(rsp_e[2]), .mem_addr_out(m_addr[2]),
    .mem_wdata_out(m_wdata[2]), .mem_we_out(m_we[2]), .mem_en_out(m_en[2]),
    .mem_rdata_in(m_rdata[2]), .tohost_valid_out(th_v[2]), .tohost_data_out(th_d[2]),
    .cycle_out(cyc[2]), .state_out(st[2]));

  // Shared BRAM: written by the latency-2 instance, read with each instance's latency.
  logic [31:0] bram [NWORDS];
  logic [31:0] r2_q, r3a_q, r3b_q;
  always @(posedge clk_in) begin
    if (m_en[1]) begin
      for (int k = 0; k < 4; k++)
        if (m_we[1][k]) bram[m_addr[1]][8*k +: 8] <= m_wdata[1][8*k +: 8];
      r2_q <= bram[m_addr[1]];
    end
    if (m_en[2]) r3a_q <= bram[m_addr[2]];
    r3b_q <= r3a_q;
  end
  assign m_rdata[0] = bram[m_addr[0]];
  assign m_rdata[1] = r2_q;
  assign m_rdata[2] = r3b_q;

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [1 << AW];
  logic [31:0] model_cycle, model_th_d;
  logic        model_th_v, model_halt, model_halt_next;
  int          tb_cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  // Scoreboard entries: {due cycle[31:0], error, rdata[31:0]}
  logic [64:0] exp_q0[$], exp_q1[$], exp_q2[$];

  always @(posedge clk_in) begin
    tb_cyc++;
    if (rst_in) begin
      model_cycle = '0;
      model_halt  = 1'b0;
    end else begin
      if (!model_halt) model_cycle = model_cycle + 32'd1;
      model_halt = model_halt_next;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h required %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int q_size(input int idx);
    case (idx)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [64:0] q_front(input int idx);
    case (idx)
      0:       return exp_q0[0];
      1:       return exp_q1[0];
      default: return exp_q2[0];
    endcase
  endfunction

  task automatic q_pop(input int idx);
    case (idx)
      0:       void'(exp_q0.pop_front());
      1:       void'(exp_q1.pop_front());
      default: void'(exp_q2.pop_front());
    endcase
  endtask

  task automatic q_push(input int idx, input logic [64:0] e);
    case (idx)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  task automatic mon_step(input int idx);
    logic [64:0] front;
    if (rsp_v[idx]) begin
      if (q_size(idx) == 0) begin
        check($sformatf("rsp_unexpected_l%0d", idx + 1), rsp_v[idx], 0);
      end else begin
        front = q_front(idx);
        q_pop(idx);
        check($sformatf("rsp_time_l%0d", idx + 1), tb_cyc, front[64:33]);
        check($sformatf("rsp_err_l%0d", idx + 1), rsp_e[idx], front[32]);
        check($sformatf("rsp_data_l%0d", idx + 1), rsp_d[idx], front[31:0]);
      end
    end else if (q_size(idx) != 0) begin
      front = q_front(idx);
      if (front[64:33] <= tb_cyc) begin
        check($sformatf("rsp_missing_l%0d", idx + 1), rsp_v[idx], 1);
        q_pop(idx);
      end
    end
  endtask

  always @(negedge clk_in) begin
    if (!rst_in) begin
      mon_step(0);
      mon_step(1);
      mon_step(2);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic uns);
    logic        acc, mis, mmio, err, en;
    logic [27:0] off;
    logic [31:0] rd, lanes;
    logic [3:0]  we;
    int          nb, base;
    @(negedge clk_in);
    req_valid_in    = 1'b1;
    req_write_in    = w;
    req_addr_in     = a;
    req_wdata_in    = d;
    req_size_in     = sz;
    req_unsigned_in = uns;
    #1;
    acc  = !model_halt;
    nb   = 1 << sz;
    mis  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    mmio = a[31:28] == 4'h8;
    off  = a[27:0];
    err  = mis || (mmio && (sz != 2'b10 || (off != 28'h0 && off != 28'h4)));
    rd = '0; we = '0; en = 1'b0; lanes = '0;
    if (acc && !err) begin
      if (mmio) begin
        if (!w) rd = (off == 28'h0) ? model_cycle : model_th_d;
      end else begin
        en   = 1'b1;
        base = int'(a[AW-1:0]);
        if (w) begin
          we    = 4'(((1 << nb) - 1) << a[1:0]);
          lanes = (nb == 1) ? {4{d[7:0]}} : (nb == 2) ? {2{d[15:0]}} : d;
        end else begin
          for (int i = 0; i < nb; i++) rd = rd | (32'(ref_mem[base + i]) << (8 * i));
          if (!uns && nb < 4 && rd[8*nb-1]) rd = rd | (32'hFFFF_FFFF << (8 * nb));
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ready_l%0d", i + 1), rdy[i], acc);
      check($sformatf("cycle_l%0d", i + 1), cyc[i], model_cycle);
      check($sformatf("tohost_d_l%0d", i + 1), th_d[i], model_th_d);
      check($sformatf("tohost_v_l%0d", i + 1), th_v[i], model_th_v);
      check($sformatf("halted_l%0d", i + 1), st[i], model_halt);
      check($sformatf("mem_en_l%0d", i + 1), m_en[i], en);
      check($sformatf("mem_we_l%0d", i + 1), m_we[i], we);
      if (en) check($sformatf("mem_addr_l%0d", i + 1), m_addr[i], a[AW-1:2]);
      if (we != 4'b0000) check($sformatf("mem_wdata_l%0d", i + 1), m_wdata[i], lanes);
    end
    if (acc) begin
      // Model side effects take effect at the accept edge.
      if (!err && !mmio && w)
        for (int i = 0; i < nb; i++) ref_mem[int'(a[AW-1:0]) + i] = d[8*i +: 8];
      if (!err && mmio && w && off == 28'h4) begin
        model_th_d = d;
        if (d[0]) begin
          model_th_v      = 1'b1;
          model_halt_next = 1'b1;
        end
      end
      for (int i = 0; i < 3; i++) q_push(i, {32'(tb_cyc + i + 1), err, rd});
    end
    @(posedge clk_in);
  endtask

  task automatic idle(input int n);
    @(negedge clk_in);
    req_valid_in = 1'b0;
    repeat (n - 1) @(negedge clk_in);
  endtask

  task automatic apply_reset;
    #2;
    rst_in          = 1'b1;
    req_valid_in    = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    model_cycle     = '0;
    model_halt      = 1'b0;
    model_halt_next = 1'b0;
    model_th_d      = '0;
    model_th_v      = 1'b0;
    #1;
    check("ready_in_reset", rdy[1], 0);
    check("rsp_valid_in_reset", rsp_v[1], 0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("post_rst_rsp_v_l%0d", i + 1), rsp_v[i], 0);
      check($sformatf("post_rst_rsp_d_l%0d", i + 1), rsp_d[i], 0);
      check($sformatf("post_rst_rsp_e_l%0d", i + 1), rsp_e[i], 0);
      check($sformatf("post_rst_th_v_l%0d", i + 1), th_v[i], 0);
      check($sformatf("post_rst_th_d_l%0d", i + 1), th_d[i], 0);
      check($sformatf("post_rst_ready_l%0d", i + 1), rdy[i], 1);
      check($sformatf("post_rst_cycle_l%0d", i + 1), cyc[i], model_cycle);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a, d, v, frozen;
    logic [1:0]  sz;
    rst_in          = 1'b1;
    req_valid_in    = 1'b0;
    req_write_in    = 1'b0;
    req_addr_in     = '0;
    req_wdata_in    = '0;
    req_size_in     = 2'b00;
    req_unsigned_in = 1'b0;
    model_cycle     = '0;
    model_halt      = 1'b0;
    model_halt_next = 1'b0;
    model_th_d      = '0;
    model_th_v      = 1'b0;
    for (int w = 0; w < NWORDS; w++) begin
      v = $urandom;
      bram[w] = v;
      for (int k = 0; k < 4; k++) ref_mem[4*w + k] = v[8*k +: 8];
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_rsp_v_l%0d", i + 1), rsp_v[i], 0);
      check($sformatf("rst_rsp_d_l%0d", i + 1), rsp_d[i], 0);
      check($sformatf("rst_cycle_l%0d", i + 1), cyc[i], 0);
      check($sformatf("rst_th_v_l%0d", i + 1), th_v[i], 0);
      check($sformatf("rst_ready_l%0d", i + 1), rdy[i], 0);
    end
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;

    // Byte store then signed/unsigned byte loads.
    do_req(1, 32'h0000_0103, 32'h0000_00A5, 2'b00, 0);
    do_req(0, 32'h0000_0103, 32'h0, 2'b00, 0);
    do_req(0, 32'h0000_0103, 32'h0, 2'b00, 1);
    idle(2);
    // Half loads plus four back-to-back loads.
    do_req(1, 32'h0000_0010, 32'h8001_7FFF, 2'b10, 0);
    do_req(0, 32'h0000_0012, 32'h0, 2'b01, 0);
    do_req(0, 32'h0000_0010, 32'h0, 2'b01, 1);
    do_req(0, 32'h0000_0010, 32'h0, 2'b10, 0);
    do_req(0, 32'h0000_0011, 32'h0, 2'b00, 0);
    do_req(0, 32'h0000_0012, 32'h0, 2'b01, 1);
    do_req(0, 32'h0000_0013, 32'h0, 2'b00, 1);
    idle(4);
    // Alignment errors; the failed half store must leave memory untouched.
    do_req(0, 32'h0000_0006, 32'h0, 2'b10, 0);
    do_req(1, 32'h0000_0001, 32'hDEAD_BEEF, 2'b01, 0);
    do_req(0, 32'h0000_0000, 32'h0, 2'b10, 0);
    do_req(0, 32'h0000_0020, 32'h0, 2'b11, 0);
    do_req(0, 32'h0000_0020, 32'h0, 2'b10, 0);
    idle($urandom_range(3, 9));
    // MMIO window.
    do_req(0, 32'h8000_0000, 32'h0, 2'b10, 0);
    do_req(1, 32'h8000_0000, 32'h1234_5677, 2'b10, 0);
    do_req(0, 32'h8000_0004, 32'h0, 2'b10, 0);
    do_req(0, 32'h8000_0008, 32'h0, 2'b10, 0);
    do_req(0, 32'h8000_0000, 32'h0, 2'b00, 0);
    do_req(1, 32'h8000_0004, 32'h0000_0042, 2'b10, 0);
    do_req(0, 32'h8000_0004, 32'h0, 2'b10, 0);
    idle(4);

    // Randomized mix of memory, aliased and MMIO traffic (never halting).
    for (int n = 0; n < 300; n++) begin
      sz = 2'($urandom_range(0, 3));
      if (sz == 2'b11 && $urandom_range(0, 3) != 0) sz = 2'b10;
      d = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        a = 32'h8000_0000 | {28'(0), 2'($urandom_range(0, 3)), 2'b00};
        d = d & ~32'h1;
      end else begin
        a = $urandom & 32'hFFFF_00FF;
        if (a[31:28] == 4'h8) a[31:28] = 4'h9;
      end
      if ($urandom_range(0, 4) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      do_req(1'($urandom_range(0, 1)), a, d, sz, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(5);

    // Halt via tohost; its own response must still drain.
    do_req(1, 32'h8000_0004, 32'h0000_0001, 2'b10, 0);
    @(negedge clk_in);
    req_valid_in = 1'b0;
    check("halt_th_v", th_v[1], 1);
    check("halt_th_d", th_d[1], 32'h1);
    check("halt_ready", rdy[1], 0);
    frozen = model_cycle;
    repeat (3) @(negedge clk_in);
    check("halt_cycle_frozen", cyc[1], frozen);
    do_req(0, 32'h0000_0010, 32'h0, 2'b10, 0);
    idle(5);

    apply_reset();
    // Reset with loads in flight: no stale responses afterwards.
    do_req(0, 32'h0000_0010, 32'h0, 2'b10, 0);
    do_req(0, 32'h0000_0014, 32'h0, 2'b10, 0);
    apply_reset();
    idle(5);
    do_req(0, 32'h0000_0020, 32'h0, 2'b10, 0);
    idle(5);

    // Counter wrap, preloaded near the top.
    @(negedge clk_in);
    force u_l2.cycle_q = 32'hFFFF_FFFF;
    #1;
    release u_l2.cycle_q;
    check("cycle_preload", cyc[1], 32'hFFFF_FFFF);
    @(negedge clk_in);
    check("cycle_wrap", cyc[1], 32'h0);

    for (int i = 0; i < 3; i++) check($sformatf("drain_l%0d", i + 1), q_size(i), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL timeout: simulation did not complete within time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
